// File: rtl/fft_pipe_stream.sv
// Streaming radix-2 DIT butterfly pipe: registered operands, B*W multiplier chain,
// add/sub with optional halving and saturation, output register; whole pipe stalls on back-pressure.
module fft_pipe_stream #(
  parameter int unsigned WORD_SIZE  = 74,
  parameter int unsigned ADDR_SIZE  = 5,
  parameter int unsigned FRAC_BITS  = 16,
  parameter int unsigned MUL_STAGES = 1
) (
  input  logic                 i_CLK,
  input  logic                 i_RST,
  input  logic                 i_valid,
  output logic                 o_ready,
  input  logic [WORD_SIZE-1:0] i_rddata_A,
  input  logic [WORD_SIZE-1:0] i_rddata_B,
  input  logic [WORD_SIZE-1:0] i_rddata_twiddle,
  input  logic [ADDR_SIZE-1:0] i_rdaddr_A,
  input  logic [ADDR_SIZE-1:0] i_rdaddr_B,
  input  logic                 i_scale,
  input  logic                 i_clr_ovf,
  output logic                 o_valid,
  input  logic                 i_ready,
  output logic [WORD_SIZE-1:0] o_wrdata_A,
  output logic [WORD_SIZE-1:0] o_wrdata_B,
  output logic [ADDR_SIZE-1:0] o_wraddr_A,
  output logic [ADDR_SIZE-1:0] o_wraddr_B,
  output logic                 o_busy,
  output logic                 o_ovf
);
  localparam int unsigned H  = WORD_SIZE / 2;
  localparam int unsigned PW = 2 * H + 1;
  localparam int unsigned SW = H + 2;
  localparam int unsigned LS = MUL_STAGES - 1;
  localparam logic signed [SW-1:0] SAT_MAX = {3'b000, {(H-1){1'b1}}};
  localparam logic signed [SW-1:0] SAT_MIN = {3'b111, {(H-1){1'b0}}};

  logic en;
  assign en      = !(o_valid && !i_ready);
  assign o_ready = en && !i_RST;

  // Stage 0: operand capture
  logic                 s0_valid, s0_scale;
  logic [WORD_SIZE-1:0] s0_a, s0_b, s0_w;
  logic [ADDR_SIZE-1:0] s0_addr_a, s0_addr_b;

  always_ff @(posedge i_CLK or posedge i_RST) begin
    if (i_RST) begin
      s0_valid  <= 1'b0;
      s0_scale  <= 1'b0;
      s0_a      <= '0;
      s0_b      <= '0;
      s0_w      <= '0;
      s0_addr_a <= '0;
      s0_addr_b <= '0;
    end else if (en) begin
      s0_valid  <= i_valid && o_ready;
      s0_scale  <= i_scale;
      s0_a      <= i_rddata_A;
      s0_b      <= i_rddata_B;
      s0_w      <= i_rddata_twiddle;
      s0_addr_a <= i_rdaddr_A;
      s0_addr_b <= i_rdaddr_B;
    end
  end

  // Complex product P = B*W in Q(FRAC_BITS), floored, kept at add width
  logic signed [PW-1:0] br_x, bi_x, wr_x, wi_x, prod_re, prod_im;
  logic signed [SW-1:0] p_re, p_im;

  always_comb begin
    br_x    = PW'($signed(s0_b[WORD_SIZE-1:H]));
    bi_x    = PW'($signed(s0_b[H-1:0]));
    wr_x    = PW'($signed(s0_w[WORD_SIZE-1:H]));
    wi_x    = PW'($signed(s0_w[H-1:0]));
    prod_re = br_x * wr_x - bi_x * wi_x;
    prod_im = br_x * wi_x + bi_x * wr_x;
    p_re    = SW'(prod_re >>> FRAC_BITS);
    p_im    = SW'(prod_im >>> FRAC_BITS);
  end

  // Multiplier register chain; index 0 holds the freshly computed product
  logic [MUL_STAGES-1:0]                m_valid, m_scale;
  logic [MUL_STAGES-1:0][SW-1:0]        m_p_re, m_p_im;
  logic [MUL_STAGES-1:0][WORD_SIZE-1:0] m_a;
  logic [MUL_STAGES-1:0][ADDR_SIZE-1:0] m_addr_a, m_addr_b;

  always_ff @(posedge i_CLK or posedge i_RST) begin
    if (i_RST) begin
      m_valid  <= '0;
      m_scale  <= '0;
      m_p_re   <= '0;
      m_p_im   <= '0;
      m_a      <= '0;
      m_addr_a <= '0;
      m_addr_b <= '0;
    end else if (en) begin
      m_valid[0]  <= s0_valid;
      m_scale[0]  <= s0_scale;
      m_p_re[0]   <= p_re;
      m_p_im[0]   <= p_im;
      m_a[0]      <= s0_a;
      m_addr_a[0] <= s0_addr_a;
      m_addr_b[0] <= s0_addr_b;
      for (int k = 1; k < MUL_STAGES; k++) begin
        m_valid[k]  <= m_valid[k-1];
        m_scale[k]  <= m_scale[k-1];
        m_p_re[k]   <= m_p_re[k-1];
        m_p_im[k]   <= m_p_im[k-1];
        m_a[k]      <= m_a[k-1];
        m_addr_a[k] <= m_addr_a[k-1];
        m_addr_b[k] <= m_addr_b[k-1];
      end
    end
  end

  // Returns {clipped, value}; halving is an arithmetic shift (floor)
  function automatic logic [H:0] scale_sat(input logic signed [SW-1:0] x, input logic sc);
    logic signed [SW-1:0] y;
    y = sc ? (x >>> 1) : x;
    if (y > SAT_MAX) return {1'b1, SAT_MAX[H-1:0]};
    if (y < SAT_MIN) return {1'b1, SAT_MIN[H-1:0]};
    return {1'b0, y[H-1:0]};
  endfunction

  logic signed [SW-1:0] a_re, a_im, pl_re, pl_im;
  logic [H:0]           res_ar, res_ai, res_br, res_bi;
  logic                 clip_any;

  always_comb begin
    a_re     = SW'($signed(m_a[LS][WORD_SIZE-1:H]));
    a_im     = SW'($signed(m_a[LS][H-1:0]));
    pl_re    = m_p_re[LS];
    pl_im    = m_p_im[LS];
    res_ar   = scale_sat(a_re + pl_re, m_scale[LS]);
    res_ai   = scale_sat(a_im + pl_im, m_scale[LS]);
    res_br   = scale_sat(a_re - pl_re, m_scale[LS]);
    res_bi   = scale_sat(a_im - pl_im, m_scale[LS]);
    clip_any = res_ar[H] | res_ai[H] | res_br[H] | res_bi[H];
  end

  // Add/sub stage and output register
  logic                 ad_valid;
  logic [WORD_SIZE-1:0] ad_a, ad_b;
  logic [ADDR_SIZE-1:0] ad_addr_a, ad_addr_b;

  always_ff @(posedge i_CLK or posedge i_RST) begin
    if (i_RST) begin
      ad_valid   <= 1'b0;
      ad_a       <= '0;
      ad_b       <= '0;
      ad_addr_a  <= '0;
      ad_addr_b  <= '0;
      o_valid    <= 1'b0;
      o_wrdata_A <= '0;
      o_wrdata_B <= '0;
      o_wraddr_A <= '0;
      o_wraddr_B <= '0;
    end else if (en) begin
      ad_valid   <= m_valid[LS];
      ad_a       <= {res_ar[H-1:0], res_ai[H-1:0]};
      ad_b       <= {res_br[H-1:0], res_bi[H-1:0]};
      ad_addr_a  <= m_addr_a[LS];
      ad_addr_b  <= m_addr_b[LS];
      o_valid    <= ad_valid;
      o_wrdata_A <= ad_a;
      o_wrdata_B <= ad_b;
      o_wraddr_A <= ad_addr_a;
      o_wraddr_B <= ad_addr_b;
    end
  end

  // Sticky overflow: a set in the same cycle as a clear takes priority
  always_ff @(posedge i_CLK or posedge i_RST) begin
    if (i_RST) begin
      o_ovf <= 1'b0;
    end else if (en && m_valid[LS] && clip_any) begin
      o_ovf <= 1'b1;
    end else if (i_clr_ovf) begin
      o_ovf <= 1'b0;
    end
  end

  assign o_busy = s0_valid | (|m_valid) | ad_valid | o_valid;

endmodule

// File: tb/tb_fft_pipe_stream.sv
// Scoreboard bench for fft_pipe_stream: directed test-plan cases plus randomized traffic
// with random back-pressure, checked against a wide-integer arithmetic reference model.
module tb_fft_pipe_stream;
  localparam int unsigned WORD_SIZE  = 74;
  localparam int unsigned ADDR_SIZE  = 5;
  localparam int unsigned FRAC_BITS  = 16;
  localparam int unsigned MUL_STAGES = 1;
  localparam int unsigned H          = WORD_SIZE / 2;
  localparam int unsigned LAT        = MUL_STAGES + 3;
  localparam longint      ONE        = longint'(1) <<< FRAC_BITS;
  localparam longint      MAXC       = (longint'(1) <<< (H - 1)) - 1;

  logic                 i_CLK = 1'b0;
  logic                 i_RST = 1'b1;
  logic                 i_valid = 1'b0, i_scale = 1'b0, i_clr_ovf = 1'b0, i_ready = 1'b1;
  logic [WORD_SIZE-1:0] i_rddata_A = '0, i_rddata_B = '0, i_rddata_twiddle = '0;
  logic [ADDR_SIZE-1:0] i_rdaddr_A = '0, i_rdaddr_B = '0;
  logic                 o_ready, o_valid, o_busy, o_ovf;
  logic [WORD_SIZE-1:0] o_wrdata_A, o_wrdata_B;
  logic [ADDR_SIZE-1:0] o_wraddr_A, o_wraddr_B;

  fft_pipe_stream #(.WORD_SIZE(WORD_SIZE), .ADDR_SIZE(ADDR_SIZE), .FRAC_BITS(FRAC_BITS),
                    .MUL_STAGES(MUL_STAGES)) dut (
    .i_CLK(i_CLK), .i_RST(i_RST), .i_valid(i_valid), .o_ready(o_ready),
    .i_rddata_A(i_rddata_A), .i_rddata_B(i_rddata_B), .i_rddata_twiddle(i_rddata_twiddle),
    .i_rdaddr_A(i_rdaddr_A), .i_rdaddr_B(i_rdaddr_B), .i_scale(i_scale),
    .i_clr_ovf(i_clr_ovf), .o_valid(o_valid), .i_ready(i_ready),
    .o_wrdata_A(o_wrdata_A), .o_wrdata_B(o_wrdata_B),
    .o_wraddr_A(o_wraddr_A), .o_wraddr_B(o_wraddr_B), .o_busy(o_busy), .o_ovf(o_ovf)
  );

  always #5 i_CLK = ~i_CLK;

  typedef struct {
    logic [WORD_SIZE-1:0] wa, wb;
    logic [ADDR_SIZE-1:0] aa, ab;
    logic                 clip;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   checks = 0, errors = 0, delivered = 0;
  bit   done = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  function automatic logic [WORD_SIZE-1:0] cpx(input longint re, input longint im);
    return {H'(re), H'(im)};
  endfunction

  function automatic logic signed [127:0] comp(input logic [WORD_SIZE-1:0] w, input bit hi);
    logic signed [H-1:0] t;
    t = hi ? w[WORD_SIZE-1:H] : w[H-1:0];
    return 128'(t);
  endfunction

  function automatic logic [H-1:0] clamp(input logic signed [127:0] x, input logic sc,
                                         output logic c);
    logic signed [127:0] y, hi, lo;
    hi = (128'sd1 <<< (H - 1)) - 128'sd1;
    lo = -(128'sd1 <<< (H - 1));
    y  = sc ? (x >>> 1) : x;
    c  = 1'b0;
    if (y > hi) begin y = hi; c = 1'b1; end
    else if (y < lo) begin y = lo; c = 1'b1; end
    return y[H-1:0];
  endfunction

  // Reference butterfly: exact complex arithmetic on wide integers, floor division, clamp
  function automatic exp_t model(input logic [WORD_SIZE-1:0] a, b, w,
                                 input logic [ADDR_SIZE-1:0] aa, ab, input logic sc);
    logic signed [127:0] ar, ai, br, bi, wr, wi, pr, pi;
    logic [H-1:0] r0, r1, r2, r3;
    logic c0, c1, c2, c3;
    exp_t e;
    ar = comp(a, 1); ai = comp(a, 0);
    br = comp(b, 1); bi = comp(b, 0);
    wr = comp(w, 1); wi = comp(w, 0);
    pr = (br * wr - bi * wi) >>> FRAC_BITS;
    pi = (br * wi + bi * wr) >>> FRAC_BITS;
    r0 = clamp(ar + pr, sc, c0);
    r1 = clamp(ai + pi, sc, c1);
    r2 = clamp(ar - pr, sc, c2);
    r3 = clamp(ai - pi, sc, c3);
    e.wa = {r0, r1};
    e.wb = {r2, r3};
    e.aa = aa;
    e.ab = ab;
    e.clip = c0 | c1 | c2 | c3;
    return e;
  endfunction

  function automatic logic [H-1:0] rnd_comp(input int bits);
    logic signed [63:0] v;
    v = signed'({$urandom, $urandom});
    v = v >>> (64 - bits);
    return v[H-1:0];
  endfunction

  function automatic logic [WORD_SIZE-1:0] rnd_word(input int bits);
    return {rnd_comp(bits), rnd_comp(bits)};
  endfunction

  function automatic logic [WORD_SIZE-1:0] rnd_tw();
    return cpx(longint'($urandom_range(0, 2 * ONE)) - ONE,
               longint'($urandom_range(0, 2 * ONE)) - ONE);
  endfunction

  // Present one butterfly until accepted; push its expected result at the accepting edge
  task automatic send(input logic [WORD_SIZE-1:0] a, b, w,
                      input logic [ADDR_SIZE-1:0] aa, ab, input logic sc);
    bit acc;
    int guard;
    i_valid = 1'b1; i_rddata_A = a; i_rddata_B = b; i_rddata_twiddle = w;
    i_rdaddr_A = aa; i_rdaddr_B = ab; i_scale = sc;
    acc = 0; guard = 0;
    while (!acc && guard < 200) begin
      @(negedge i_CLK);
      acc = o_ready;
      if (acc) sb.push_back(model(a, b, w, aa, ab, sc));
      @(posedge i_CLK); #1;
      guard++;
    end
    if (!acc) begin
      checks++; errors++;
      $display("FAIL send_timeout: got not-accepted expected accepted");
    end
  endtask

  task automatic run_one(input string name, input logic [WORD_SIZE-1:0] a, b, w,
                         input logic [ADDR_SIZE-1:0] aa, ab, input logic sc,
                         input logic [WORD_SIZE-1:0] ea, eb);
    int cnt;
    bit got;
    send(a, b, w, aa, ab, sc);
    i_valid = 1'b0;
    cnt = 1; got = 0;
    while (!got && cnt < 20) begin
      @(negedge i_CLK);
      if (o_valid) got = 1;
      else begin @(posedge i_CLK); #1; cnt++; end
    end
    chk({name, "_latency"}, 128'(cnt), 128'(LAT));
    chk({name, "_A"}, 128'(o_wrdata_A), 128'(ea));
    chk({name, "_B"}, 128'(o_wrdata_B), 128'(eb));
    chk({name, "_addrA"}, 128'(o_wraddr_A), 128'(aa));
    chk({name, "_addrB"}, 128'(o_wraddr_B), 128'(ab));
    @(posedge i_CLK); #1;
  endtask

  task automatic drain(input string name);
    int g;
    g = 0;
    while ((sb.size() != 0 || o_valid) && g < 500) begin @(negedge i_CLK); g++; end
    chk({name, "_drained"}, 128'(sb.size()), 128'(0));
    @(posedge i_CLK); #1;
  endtask

  // Monitor: every delivered result must match the oldest outstanding expectation
  always @(negedge i_CLK) begin
    if (!i_RST && o_valid && i_ready) begin
      if (sb.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_out: got o_valid=1 expected no result pending");
      end else begin
        mon_e = sb.pop_front();
        chk("mon_wrdata_A", 128'(o_wrdata_A), 128'(mon_e.wa));
        chk("mon_wrdata_B", 128'(o_wrdata_B), 128'(mon_e.wb));
        chk("mon_wraddr_A", 128'(o_wraddr_A), 128'(mon_e.aa));
        chk("mon_wraddr_B", 128'(o_wraddr_B), 128'(mon_e.ab));
        if (mon_e.clip) chk("mon_ovf", 128'(o_ovf), 128'(1));
        delivered++;
      end
    end
  end

  initial begin
    int base;
    logic [WORD_SIZE-1:0] unity, ab_a, ab_b;
    unity = cpx(ONE, 0);
    ab_a  = cpx(100, 50);
    ab_b  = cpx(30, -20);

    #1;
    chk("rst_valid", 128'(o_valid), 128'(0));
    chk("rst_ready", 128'(o_ready), 128'(0));
    chk("rst_busy", 128'(o_busy), 128'(0));
    chk("rst_ovf", 128'(o_ovf), 128'(0));
    chk("rst_data", 128'({o_wrdata_A, o_wrdata_B}), 128'(0));
    repeat (2) @(posedge i_CLK);
    @(negedge i_CLK); i_RST = 1'b0;
    #1 chk("rel_ready", 128'(o_ready), 128'(1));
    @(posedge i_CLK); #1;

    run_one("unity", ab_a, ab_b, unity, 5'd3, 5'd19, 1'b0, cpx(130, 30), cpx(70, 70));
    run_one("minus_j", ab_a, ab_b, cpx(0, -ONE), 5'd7, 5'd23, 1'b0, cpx(80, 20), cpx(120, 80));
    run_one("scale", ab_a, ab_b, unity, 5'd1, 5'd17, 1'b1, cpx(65, 15), cpx(35, 35));
    run_one("scale_neg", cpx(-3, 0), '0, unity, 5'd2, 5'd18, 1'b1, cpx(-2, 0), cpx(-2, 0));
    chk("no_ovf_yet", 128'(o_ovf), 128'(0));
    run_one("sat", cpx(MAXC, 0), cpx(MAXC, 0), unity, 5'd4, 5'd20, 1'b0,
            cpx(MAXC, 0), cpx(0, 0));
    chk("sat_ovf", 128'(o_ovf), 128'(1));

    for (int i = 0; i < 10; i++)
      send(rnd_word(20), rnd_word(20), rnd_tw(), 5'(i), 5'(i + 16), 1'($urandom));
    i_valid = 1'b0;
    drain("clean");
    chk("ovf_sticky", 128'(o_ovf), 128'(1));
    i_clr_ovf = 1'b1;
    @(posedge i_CLK); #1;
    i_clr_ovf = 1'b0;
    chk("ovf_cleared", 128'(o_ovf), 128'(0));

    // Back-pressure: 8 back-to-back with a 3-cycle i_ready gap mid-stream
    base = delivered;
    fork
      begin
        for (int i = 0; i < 8; i++)
          send(rnd_word(24), rnd_word(24), rnd_tw(), 5'(i + 8), 5'(i + 24), 1'b0);
        i_valid = 1'b0;
      end
      begin
        int g;
        g = 0;
        while (!o_valid && g < 50) begin @(posedge i_CLK); #1; g++; end
        i_ready = 1'b0;
        repeat (3) begin
          @(negedge i_CLK);
          chk("stall_ready", 128'(o_ready), 128'(0));
          chk("stall_valid", 128'(o_valid), 128'(1));
          if (sb.size() != 0) begin
            chk("stall_hold_A", 128'(o_wrdata_A), 128'(sb[0].wa));
            chk("stall_hold_addrA", 128'(o_wraddr_A), 128'(sb[0].aa));
          end
          @(posedge i_CLK); #1;
        end
        i_ready = 1'b1;
      end
    join
    drain("bp");
    chk("bp_count", 128'(delivered - base), 128'(8));
    chk("bp_busy_low", 128'(o_busy), 128'(0));

    // Randomized traffic with random back-pressure
    done = 0;
    fork
      begin
        for (int i = 0; i < 200; i++) begin
          if ($urandom_range(0, 3) == 0) begin
            i_valid = 1'b0;
            @(posedge i_CLK); #1;
          end
          send(rnd_word(($urandom_range(0, 7) == 0) ? H : 20),
               rnd_word(($urandom_range(0, 7) == 0) ? H : 20),
               rnd_tw(), 5'($urandom), 5'($urandom), 1'($urandom));
        end
        i_valid = 1'b0;
        done = 1;
      end
      begin
        int g;
        g = 0;
        while (!done && g < 5000) begin
          @(posedge i_CLK); #1;
          i_ready = ($urandom_range(0, 3) != 0);
          g++;
        end
        i_ready = 1'b1;
      end
    join
    drain("random");

    // Reset with three butterflies in flight
    for (int i = 0; i < 3; i++)
      send(rnd_word(20), rnd_word(20), rnd_tw(), 5'(i), 5'(i), 1'b0);
    i_valid = 1'b0;
    #2 i_RST = 1'b1;
    #1;
    chk("mid_rst_valid", 128'(o_valid), 128'(0));
    chk("mid_rst_busy", 128'(o_busy), 128'(0));
    chk("mid_rst_ready", 128'(o_ready), 128'(0));
    chk("mid_rst_ovf", 128'(o_ovf), 128'(0));
    chk("mid_rst_data", 128'({o_wrdata_A, o_wrdata_B}), 128'(0));
    chk("mid_rst_addr", 128'({o_wraddr_A, o_wraddr_B}), 128'(0));
    sb.delete();
    @(negedge i_CLK); i_RST = 1'b0;
    #1;
    chk("post_rst_ready", 128'(o_ready), 128'(1));
    chk("post_rst_busy", 128'(o_busy), 128'(0));
    repeat (10) @(posedge i_CLK);
    #1 chk("post_rst_idle", 128'(o_busy), 128'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
